blk_64cfbb: RTL and testbench

Parametrised, optionally pipelined max-priority reduction tree for the platform-level interrupt controller (PLIC) gateway-to-target path. It compares N interrupt sources and selects the pending, enabled source with the highest priority, breaking ties towards the lowest source ID. It also compares the winner against the target's threshold and registers the result with a valid strobe. One instance sits per interrupt target, between the pending/enable/priority register banks and the claim/complete logic.

---
 rtl/blk_64cfbb.sv | 119 +++++++++++
 tb/tb_blk_64cfbb.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_64cfbb.sv
// PLIC per-target max-priority reduction tree with threshold compare and registered result.
// Define PLATFORM_LEVEL_INTERRUPT_CONTROLLER__PRIORITY_TREE_PIPELINE_EN to register every tree level.
module blk_64cfbb #(
    parameter int N_SOURCES      = 32,
    parameter int ID_WIDTH       = 10,
    parameter int PRIORITY_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [N_SOURCES-1:0]                ip,
    input  logic [N_SOURCES-1:0]                ie,
    input  logic [N_SOURCES*PRIORITY_WIDTH-1:0] src_priority,
    input  logic [PRIORITY_WIDTH-1:0]           threshold,
    output logic                                out_valid,
    output logic [ID_WIDTH-1:0]                 id_max,
    output logic [PRIORITY_WIDTH-1:0]           priority_max,
    output logic                                irq
);

    localparam int LEVELS = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 0;
    localparam int P      = 1 << LEVELS;

`ifdef PLATFORM_LEVEL_INTERRUPT_CONTROLLER__PRIORITY_TREE_PIPELINE_EN
    localparam bit PIPE_EN = 1'b1;
`else
    localparam bit PIPE_EN = 1'b0;
`endif

    // Valid and threshold travel alongside the data so each result meets its own threshold.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        logic                      vld;
        logic [PRIORITY_WIDTH-1:0] thr;
        if (l == 0) begin : g_in
            assign vld = in_valid;
            assign thr = threshold;
        end else if (PIPE_EN && l < LEVELS) begin : g_reg
            // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld <= 1'b0;
                    thr <= '0;
                end else begin
                    vld <= g_lvl[l-1].vld;
                    if (g_lvl[l-1].vld) thr <= g_lvl[l-1].thr;
                end
            end
        end else begin : g_pass
            assign vld = g_lvl[l-1].vld;
            assign thr = g_lvl[l-1].thr;
        end
    end

    // Heap-indexed tree: node 1 is the root, nodes P..2P-1 are leaves, children of k are 2k and 2k+1.
    for (genvar k = 1; k < 2 * P; k++) begin : g_node
        logic [PRIORITY_WIDTH-1:0] pri;
        logic [ID_WIDTH-1:0]       id;
        if (k >= P) begin : g_leaf
            if (k - P < N_SOURCES) begin : g_src
                assign pri = (ip[k-P] && ie[k-P]) ? src_priority[(k-P)*PRIORITY_WIDTH +: PRIORITY_WIDTH] : '0;
                assign id  = ID_WIDTH'(k - P + 1);
            end else begin : g_pad
                assign pri = '0;
                assign id  = '0;
            end
        end else begin : g_int
            localparam int LV = LEVELS - ($clog2(k + 1) - 1);
            logic                      b_wins;
            logic [PRIORITY_WIDTH-1:0] sel_pri;
            logic [ID_WIDTH-1:0]       sel_id;
            // Strictly greater keeps the lower-ID child on a tie.
            assign b_wins  = g_node[2*k+1].pri > g_node[2*k].pri;
            assign sel_pri = b_wins ? g_node[2*k+1].pri : g_node[2*k].pri;
            assign sel_id  = b_wins ? g_node[2*k+1].id  : g_node[2*k].id;
            if (PIPE_EN && LV < LEVELS) begin : g_reg
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        pri <= '0;
                        id  <= '0;
                    end else if (g_lvl[LV-1].vld) begin
                        pri <= sel_pri;
                        id  <= sel_id;
                    end
                end
            end else begin : g_comb
                assign pri = sel_pri;
                assign id  = sel_id;
            end
        end
    end

    logic                      root_vld;
    logic [PRIORITY_WIDTH-1:0] root_thr;
    logic [PRIORITY_WIDTH-1:0] root_pri;
    logic [ID_WIDTH-1:0]       root_id;

    assign root_vld = g_lvl[LEVELS].vld;
    assign root_thr = g_lvl[LEVELS].thr;
    assign root_pri = g_node[1].pri;
    assign root_id  = g_node[1].id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            id_max       <= '0;
            priority_max <= '0;
            irq          <= 1'b0;
        end else begin
            out_valid <= root_vld;
            if (root_vld) begin
                // An all-zero tree still carries the lowest leaf ID; report it as "no interrupt".
                id_max       <= (root_pri == '0) ? '0 : root_id;
                priority_max <= root_pri;
                irq          <= root_pri > root_thr;
            end
        end
    end

endmodule

// File: tb/tb_blk_64cfbb.sv
// Self-checking bench for blk_64cfbb: directed PLIC scenarios plus randomized samples against a flat scan model.
module tb_blk_64cfbb;

    localparam int N   = 32;
    localparam int IW  = 10;
    localparam int PW  = 32;
    localparam int N5  = 5;
    localparam int IW5 = 3;
    localparam int PW5 = 8;
`ifdef PLATFORM_LEVEL_INTERRUPT_CONTROLLER__PRIORITY_TREE_PIPELINE_EN
    localparam int LAT  = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam int LAT5 = 3;
`else
    localparam int LAT  = 1;
    localparam int LAT5 = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [N-1:0]    ip, ie;
    logic [PW-1:0]   prio [N];
    logic [N*PW-1:0] src_priority;
    logic [PW-1:0]   threshold;
    logic            out_valid;
    logic [IW-1:0]   id_max;
    logic [PW-1:0]   priority_max;
    logic            irq;

    logic             in_valid5;
    logic [N5-1:0]    ip5, ie5;
    logic [PW5-1:0]   prio5 [N5];
    logic [N5*PW5-1:0] src_priority5;
    logic [PW5-1:0]   threshold5;
    logic             out_valid5;
    logic [IW5-1:0]   id_max5;
    logic [PW5-1:0]   priority_max5;
    logic             irq5;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        src_priority = '0;
        for (int i = 0; i < N; i++) src_priority[i*PW +: PW] = prio[i];
        src_priority5 = '0;
        for (int i = 0; i < N5; i++) src_priority5[i*PW5 +: PW5] = prio5[i];
    end

    blk_64cfbb #(.N_SOURCES(N), .ID_WIDTH(IW), .PRIORITY_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ip(ip), .ie(ie),
        .src_priority(src_priority), .threshold(threshold), .out_valid(out_valid),
        .id_max(id_max), .priority_max(priority_max), .irq(irq)
    );

    blk_64cfbb #(.N_SOURCES(N5), .ID_WIDTH(IW5), .PRIORITY_WIDTH(PW5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .ip(ip5), .ie(ie5),
        .src_priority(src_priority5), .threshold(threshold5), .out_valid(out_valid5),
        .id_max(id_max5), .priority_max(priority_max5), .irq(irq5)
    );

    // Reference: linear scan, first strictly-greater effective priority wins.
    function automatic void model(output logic [IW-1:0] eid, output logic [PW-1:0] ep, output logic eirq);
        eid = '0;
        ep  = '0;
        for (int i = 0; i < N; i++)
            if (ip[i] && ie[i] && prio[i] > ep) begin
                ep  = prio[i];
                eid = IW'(i + 1);
            end
        eirq = ep > threshold;
    endfunction

    function automatic void model5(output logic [IW5-1:0] eid, output logic [PW5-1:0] ep, output logic eirq);
        eid = '0;
        ep  = '0;
        for (int i = 0; i < N5; i++)
            if (ip5[i] && ie5[i] && prio5[i] > ep) begin
                ep  = prio5[i];
                eid = IW5'(i + 1);
            end
        eirq = ep > threshold5;
    endfunction

    task automatic clear_inputs();
        ip = '0;
        ie = '0;
        threshold = '0;
        for (int i = 0; i < N; i++) prio[i] = '0;
    endtask

    // One sample on the main instance; out_valid must pulse exactly once, LAT cycles later, then hold data.
    task automatic run_one(input string name, input logic [IW-1:0] eid, input logic [PW-1:0] ep, input logic eirq);
        int seen_at = -1;
        int nseen   = 0;
        @(negedge clk);
        in_valid = 1'b1;
        for (int c = 1; c <= LAT + 2; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
            if (out_valid) begin
                nseen++;
                if (seen_at < 0) seen_at = c;
            end
        end
        checks++;
        if (seen_at != LAT || nseen != 1) begin
            failures++;
            $display("FAIL %s latency: out_valid at cycle %0d count %0d, required cycle %0d count 1", name, seen_at, nseen, LAT);
        end
        checks++;
        if (id_max !== eid) begin
            failures++;
            $display("FAIL %s id_max: got %0d required %0d", name, id_max, eid);
        end
        checks++;
        if (priority_max !== ep) begin
            failures++;
            $display("FAIL %s priority_max: got %0d required %0d", name, priority_max, ep);
        end
        checks++;
        if (irq !== eirq) begin
            failures++;
            $display("FAIL %s irq: got %0b required %0b", name, irq, eirq);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid5 = 1'b0;
        clear_inputs();
        ip5 = '0; ie5 = '0; threshold5 = '0;
        for (int i = 0; i < N5; i++) prio5[i] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, id_max, priority_max, irq} !== '0) begin
            failures++;
            $display("FAIL reset_main: got v=%0b id=%0d p=%0d irq=%0b required all 0", out_valid, id_max, priority_max, irq);
        end
        checks++;
        if ({out_valid5, id_max5, priority_max5, irq5} !== '0) begin
            failures++;
            $display("FAIL reset_n5: got v=%0b id=%0d p=%0d irq=%0b required all 0", out_valid5, id_max5, priority_max5, irq5);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_winner();
        clear_inputs();
        ip = '1;
        ie = '1;
        for (int i = 0; i < N; i++) prio[i] = 1;
        prio[7] = 5;
        run_one("single_winner", 10'd8, 32'd5, 1'b1);
    endtask

    task automatic test_tie_break();
        clear_inputs();
        ip = '1;
        ie = '1;
        prio[3]  = 9;
        prio[20] = 9;
        run_one("tie_break", 10'd4, 32'd9, 1'b1);
    endtask

    task automatic test_mask_threshold();
        clear_inputs();
        ip = '1;
        ie = '1;
        ie[7] = 1'b0;
        prio[7] = 7;
        prio[2] = 3;
        threshold = 3;
        run_one("mask_threshold", 10'd3, 32'd3, 1'b0);
    endtask

    task automatic test_no_interrupt();
        clear_inputs();
        ie = '1;
        for (int i = 0; i < N; i++) prio[i] = 32'(i + 4);
        run_one("no_interrupt", 10'd0, 32'd0, 1'b0);
    endtask

    task automatic test_random();
        logic [IW-1:0] eid;
        logic [PW-1:0] ep;
        logic          eirq;
        for (int t = 0; t < 24; t++) begin
            ip = $urandom;
            ie = $urandom;
            for (int i = 0; i < N; i++)
                prio[i] = (t >= 18) ? PW'($urandom) : PW'($urandom_range(0, 7));
            threshold = (t >= 18) ? PW'($urandom) : PW'($urandom_range(0, 7));
            model(eid, ep, eirq);
            run_one($sformatf("random_%0d", t), eid, ep, eirq);
        end
    endtask

    typedef struct {
        int            due;
        logic [IW-1:0] id;
        logic [PW-1:0] pri;
        logic          irq;
    } exp_t;

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        int   n = 16;
        @(negedge clk);
        for (int c = 0; c <= n + LAT + 1; c++) begin
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || id_max !== e.id || priority_max !== e.pri || irq !== e.irq) begin
                    failures++;
                    $display("FAIL back_to_back cycle %0d: got v=%0b id=%0d p=%0d irq=%0b required v=1 id=%0d p=%0d irq=%0b",
                             c, out_valid, id_max, priority_max, irq, e.id, e.pri, e.irq);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL back_to_back idle cycle %0d: got out_valid=%0b required 0", c, out_valid);
                end
            end
            if (c < n) begin
                ip = $urandom;
                ie = $urandom;
                for (int i = 0; i < N; i++) prio[i] = PW'($urandom_range(0, 15));
                threshold = PW'($urandom_range(0, 15));
                model(e.id, e.pri, e.irq);
                e.due = c + LAT;
                q.push_back(e);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL back_to_back drain: %0d results missing, required 0", q.size());
        end
    endtask

    task automatic test_stream_reset();
        logic [PW-1:0] sent_pri [10];
        logic          sent_irq [10];
        int got = 0;
        clear_inputs();
        ie = '1;
        @(negedge clk);
        for (int c = 0; c < 10 + LAT + 2; c++) begin
            if (c >= LAT && c - LAT < 10) begin
                checks++;
                if (out_valid !== 1'b1 || id_max !== IW'(c - LAT + 1) ||
                    priority_max !== sent_pri[c-LAT] || irq !== sent_irq[c-LAT]) begin
                    failures++;
                    $display("FAIL stream_%0d: got v=%0b id=%0d p=%0d irq=%0b required v=1 id=%0d p=%0d irq=%0b",
                             c - LAT, out_valid, id_max, priority_max, irq, c - LAT + 1, sent_pri[c-LAT], sent_irq[c-LAT]);
                end
                got++;
            end
            if (got == 4) break;
            if (c < 10) begin
                ip = N'(1) << c;
                prio[c] = PW'($urandom_range(1, 1000));
                threshold = PW'($urandom_range(0, 1000));
                sent_pri[c] = prio[c];
                sent_irq[c] = prio[c] > threshold;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            checks++;
            if ({out_valid, id_max, priority_max, irq} !== '0) begin
                failures++;
                $display("FAIL stream_after_reset cycle %0d: got v=%0b id=%0d p=%0d irq=%0b required all 0",
                         c, out_valid, id_max, priority_max, irq);
            end
            @(negedge clk);
        end
        clear_inputs();
        ip = N'(1) << 12;
        ie = '1;
        prio[12] = 40;
        threshold = 39;
        run_one("stream_restart", 10'd13, 32'd40, 1'b1);
    endtask

    task automatic test_odd_size();
        logic [IW5-1:0] eid;
        logic [PW5-1:0] ep;
        logic           eirq;
        int seen_at, nseen;
        for (int t = 0; t < 6; t++) begin
            if (t == 0) begin
                ip5 = 5'b10000;
                ie5 = '1;
                for (int i = 0; i < N5; i++) prio5[i] = 8'd6;
                prio5[4] = 8'd2;
                threshold5 = '0;
                eid = 3'd5; ep = 8'd2; eirq = 1'b1;
            end else begin
                ip5 = $urandom;
                ie5 = $urandom;
                for (int i = 0; i < N5; i++) prio5[i] = PW5'($urandom_range(0, 255));
                threshold5 = PW5'($urandom_range(0, 255));
                model5(eid, ep, eirq);
            end
            seen_at = -1;
            nseen = 0;
            @(negedge clk);
            in_valid5 = 1'b1;
            for (int c = 1; c <= LAT5 + 2; c++) begin
                @(negedge clk);
                if (c == 1) in_valid5 = 1'b0;
                if (out_valid5) begin
                    nseen++;
                    if (seen_at < 0) seen_at = c;
                end
            end
            checks++;
            if (seen_at != LAT5 || nseen != 1 || id_max5 !== eid || priority_max5 !== ep || irq5 !== eirq) begin
                failures++;
                $display("FAIL odd_size_%0d: got lat=%0d cnt=%0d id=%0d p=%0d irq=%0b required lat=%0d cnt=1 id=%0d p=%0d irq=%0b",
                         t, seen_at, nseen, id_max5, priority_max5, irq5, LAT5, eid, ep, eirq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_winner();
        test_tie_break();
        test_mask_threshold();
        test_no_interrupt();
        test_random();
        test_back_to_back();
        test_stream_reset();
        test_odd_size();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
